// File: rtl/bcd_down_counter_pkg.sv
// Shared constants, helpers and operation encoding for the BCD down counter.
// The two digit helpers are the only places where the 0..9 range is enforced.
package bcd_down_counter_pkg;

    localparam int          DIGIT_W  = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    // Operation selected on a clock edge, already resolved for priority.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_DEC   = 2'd2,
        OP_RESET = 2'd3
    } op_e;

    // Any non-decimal nibble (A..F) is loaded as 9.
    function automatic logic [DIGIT_W-1:0] clampDigit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // One decade step downwards; 0 rolls to 9 and the caller handles the borrow.
    function automatic logic [DIGIT_W-1:0] decDigit(input logic [DIGIT_W-1:0] d);
        return (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_down_counter_digit.sv
// One BCD decade of the down counter: clamp-on-load register with a 0 -> 9
// borrow step. Borrow ripples onwards only while this digit sits at zero.
module bcd_digit_down
    import bcd_down_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero,
    output logic               borrow_out
);

    logic [DIGIT_W-1:0] digit_d;
    logic [DIGIT_W-1:0] digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = clampDigit(load_digit);
        end else if (borrow_in) begin
            digit_d = decDigit(digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign is_zero    = (digit_q == BCD_ZERO);
    assign borrow_out = borrow_in & is_zero;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with parallel load, terminal-count flags and
// optional wrap from all-zero to all-nines.
module bcd_down_counter
    import bcd_down_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter bit WRAP   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    input  logic                    en,
    output logic [4*DIGITS-1:0]     count,
    output logic                    zero,
    output logic                    done,
    output logic                    wrapped
);

    logic [DIGITS:0]        borrow;
    logic [DIGITS-1:0]      digitZero;
    logic [4*DIGITS-1:0]    countVal;
    logic                   allZero;
    logic                   upperZero;
    logic                   isOne;
    logic                   loadZero;
    op_e                    op;

    logic zero_d, zero_q;
    logic done_d, done_q;
    logic wrapped_d, wrapped_q;

    // Without WRAP the chain is never started at zero, so the count holds.
    assign allZero   = &digitZero;
    assign borrow[0] = WRAP ? (en & ~load) : (en & ~load & ~allZero);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_down u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[DIGIT_W*k +: DIGIT_W]),
            .borrow_in  (borrow[k]),
            .digit      (countVal[DIGIT_W*k +: DIGIT_W]),
            .is_zero    (digitZero[k]),
            .borrow_out (borrow[k+1])
        );
    end

    if (DIGITS == 1) begin : g_upper_one
        assign upperZero = 1'b1;
    end else begin : g_upper_many
        assign upperZero = &digitZero[DIGITS-1:1];
    end

    // Clamping never turns a nonzero digit into zero, so the raw preset suffices.
    assign isOne    = (countVal[DIGIT_W-1:0] == 4'd1) && upperZero;
    assign loadZero = (load_val == '0);

    always_comb begin
        op = OP_IDLE;
        if (rst) begin
            op = OP_RESET;
        end else if (load) begin
            op = OP_LOAD;
        end else if (en) begin
            op = OP_DEC;
        end
    end

    // Flags follow the value the digits take on this edge; a borrow out of the
    // top digit can only mean a wrap from all-zero.
    always_comb begin
        zero_d    = zero_q;
        done_d    = 1'b0;
        wrapped_d = 1'b0;
        case (op)
            OP_RESET: zero_d = 1'b1;
            OP_LOAD:  zero_d = loadZero;
            OP_DEC: begin
                if (allZero) begin
                    zero_d    = ~borrow[DIGITS];
                    wrapped_d = borrow[DIGITS];
                end else begin
                    zero_d = isOne;
                    done_d = isOne;
                end
            end
            default:  zero_d = zero_q;
        endcase
    end

    always_ff @(posedge clk) begin
        zero_q    <= zero_d;
        done_q    <= done_d;
        wrapped_q <= wrapped_d;
    end

    assign count   = countVal;
    assign zero    = zero_q;
    assign done    = done_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench: three counters (2 digits hold, 2 digits wrap, 4 digits
// wrap) share stimulus; an integer countdown model supplies expected values.
module tb_bcd_down_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        en;
    logic [15:0] loadVal;

    logic [7:0]  count0, count1;
    logic [15:0] count4;
    logic        zero0, zero1, zero4;
    logic        done0, done1, done4;
    logic        wrapped0, wrapped1, wrapped4;

    int checks   = 0;
    int failures = 0;

    int mVal[3];
    bit mDone[3];
    bit mWrap[3];
    int mDigits[3]   = '{2, 2, 4};
    bit mWrapMode[3] = '{1'b0, 1'b1, 1'b1};

    logic [15:0] obsCount[3];
    logic        obsZero[3];
    logic        obsDone[3];
    logic        obsWrap[3];

    always #5 clk = ~clk;

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .load_val(loadVal[7:0]), .en(en),
        .count(count0), .zero(zero0), .done(done0), .wrapped(wrapped0));

    bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .load_val(loadVal[7:0]), .en(en),
        .count(count1), .zero(zero1), .done(done1), .wrapped(wrapped1));

    bcd_down_counter #(.DIGITS(4), .WRAP(1'b1)) dut4 (
        .clk(clk), .rst(rst), .load(load), .load_val(loadVal), .en(en),
        .count(count4), .zero(zero4), .done(done4), .wrapped(wrapped4));

    assign obsCount[0] = {8'h00, count0};
    assign obsCount[1] = {8'h00, count1};
    assign obsCount[2] = count4;
    assign obsZero[0]  = zero0;
    assign obsZero[1]  = zero1;
    assign obsZero[2]  = zero4;
    assign obsDone[0]  = done0;
    assign obsDone[1]  = done1;
    assign obsDone[2]  = done4;
    assign obsWrap[0]  = wrapped0;
    assign obsWrap[1]  = wrapped1;
    assign obsWrap[2]  = wrapped4;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int presetValue(input logic [15:0] lv, input int digits);
        int v = 0;
        int p = 1;
        int nib;
        for (int k = 0; k < digits; k++) begin
            nib = int'(lv[4*k +: 4]);
            if (nib > 9) nib = 9;
            v = v + nib * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic int maxValue(input int digits);
        int p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        return p - 1;
    endfunction

    // Advance one clock edge and apply the counting rules to the model.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            mDone[i] = 1'b0;
            mWrap[i] = 1'b0;
            if (rst) begin
                mVal[i] = 0;
            end else if (load) begin
                mVal[i] = presetValue(loadVal, mDigits[i]);
            end else if (en) begin
                if (mVal[i] > 0) begin
                    mDone[i] = (mVal[i] == 1);
                    mVal[i]  = mVal[i] - 1;
                end else if (mWrapMode[i]) begin
                    mVal[i]  = maxValue(mDigits[i]);
                    mWrap[i] = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0; loadVal = 16'h0025;
        tick();
        tick();
        checks++;
        if (count0 !== 8'h00 || zero0 !== 1'b1) begin
            failures++;
            $display("FAIL reset_state actual=%h zero=%b required=00 zero=1", count0, zero0);
        end
        checks++;
        if (done0 !== 1'b0 || wrapped1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulses actual done=%b wrapped=%b required 0 0", done0, wrapped1);
        end
        rst = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count0 !== 8'h25 || zero0 !== 1'b0) begin
            failures++;
            $display("FAIL load_25 actual=%h zero=%b required=25 zero=0", count0, zero0);
        end
    endtask

    task automatic test_borrow();
        int pulses = 0;
        load = 1'b1; loadVal = 16'h0010;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        checks++;
        if (count0 !== 8'h09 || count1 !== 8'h09 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL borrow_10_to_09 actual=%h/%h done=%b required=09/09 done=0", count0, count1, done0);
        end
        for (int n = 0; n < 9; n++) begin
            tick();
            if (done0 === 1'b1) pulses++;
            if (n == 8) begin
                checks++;
                if (done0 !== 1'b1) begin
                    failures++;
                    $display("FAIL done_on_01_to_00 actual=%b required=1", done0);
                end
            end
        end
        checks++;
        if (count0 !== 8'h00 || zero0 !== 1'b1 || pulses != 1) begin
            failures++;
            $display("FAIL countdown_end actual=%h zero=%b pulses=%0d required=00 zero=1 pulses=1", count0, zero0, pulses);
        end
    endtask

    task automatic test_hold_wrap();
        logic [7:0] expWrapCount[3] = '{8'h99, 8'h98, 8'h97};
        logic       expWrapped[3]   = '{1'b1, 1'b0, 1'b0};
        en = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (count0 !== 8'h00 || done0 !== 1'b0 || zero0 !== 1'b1) begin
                failures++;
                $display("FAIL hold_at_zero cycle %0d actual=%h done=%b zero=%b required=00 done=0 zero=1", n, count0, done0, zero0);
            end
            checks++;
            if (count1 !== expWrapCount[n] || wrapped1 !== expWrapped[n] || zero1 !== 1'b0) begin
                failures++;
                $display("FAIL wrap cycle %0d actual=%h wrapped=%b zero=%b required=%h wrapped=%b zero=0",
                         n, count1, wrapped1, zero1, expWrapCount[n], expWrapped[n]);
            end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_invalid_load();
        load = 1'b1; loadVal = 16'hFFA3;
        tick();
        checks++;
        if (count0 !== 8'h93 || count4 !== 16'h9993) begin
            failures++;
            $display("FAIL clamp_A3 actual=%h/%h required=93/9993", count0, count4);
        end
        loadVal = 16'h00FF;
        tick();
        load = 1'b0;
        checks++;
        if (count0 !== 8'h99 || zero0 !== 1'b0) begin
            failures++;
            $display("FAIL clamp_FF actual=%h zero=%b required=99 zero=0", count0, zero0);
        end
    endtask

    task automatic test_priority();
        load = 1'b1; loadVal = 16'h0040;
        tick();
        en = 1'b1; loadVal = 16'h0007;
        tick();
        checks++;
        if (count0 !== 8'h07 || count1 !== 8'h07 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL load_over_en actual=%h/%h done=%b required=07/07 done=0", count0, count1, done0);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (count0 !== 8'h00 || zero0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_over_load actual=%h zero=%b required=00 zero=1", count0, zero0);
        end
        rst = 1'b0; loadVal = 16'h0013;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (count0 !== 8'h12) begin
            failures++;
            $display("FAIL count_13_to_12 actual=%h required=12", count0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (count0 !== 8'h00 || zero0 !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_run actual=%h zero=%b required=00 zero=1", count0, zero0);
        end
        load = 1'b1; loadVal = 16'h0005;
        tick();
        loadVal = 16'h0000;
        tick();
        checks++;
        if (count0 !== 8'h00 || zero0 !== 1'b1 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL load_zero actual=%h zero=%b done=%b required=00 zero=1 done=0", count0, zero0, done0);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_digits4();
        load = 1'b1; loadVal = 16'h1000;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (count4 !== 16'h0999 || zero4 !== 1'b0) begin
            failures++;
            $display("FAIL d4_borrow actual=%h zero=%b required=0999 zero=0", count4, zero4);
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (count4 !== 16'h0999 || done4 !== 1'b0 || wrapped4 !== 1'b0) begin
                failures++;
                $display("FAIL d4_idle cycle %0d actual=%h done=%b wrapped=%b required=0999 0 0", n, count4, done4, wrapped4);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 6) == 0);
            en   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) == 0) loadVal = 16'($urandom_range(0, 3));
            else                            loadVal = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obsCount[i] !== toBcd(mVal[i]) || obsZero[i] !== (mVal[i] == 0) ||
                    obsDone[i] !== mDone[i] || obsWrap[i] !== mWrap[i]) begin
                    failures++;
                    $display("FAIL random dut%0d cycle %0d actual=%h z%b d%b w%b required=%h z%b d%b w%b",
                             i, n, obsCount[i], obsZero[i], obsDone[i], obsWrap[i],
                             toBcd(mVal[i]), (mVal[i] == 0), mDone[i], mWrap[i]);
                end
            end
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mVal[i]  = 0;
            mDone[i] = 1'b0;
            mWrap[i] = 1'b0;
        end
        rst = 1'b1; load = 1'b0; en = 1'b0; loadVal = '0;
        test_reset();
        test_borrow();
        test_hold_wrap();
        test_invalid_load();
        test_priority();
        test_digits4();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous multi-digit BCD (decade) down counter, the count-down counterpart of the team's decade up counter.
- Parallel-loads a BCD preset, decrements once per enabled clock with digit-to-digit borrow, and flags terminal count.
- Used as a countdown timer or event-remaining counter feeding display and control logic.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS.
- WRAP, 0, behaviour at all-zero: 0 = hold at zero, 1 = wrap to all-nines.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- load  input  1  parallel load strobe
- load_val  input  4*DIGITS  BCD preset; digit k is bits [4k+3:4k], digit 0 is least significant
- en  input  1  count enable, one decrement per cycle
- count  output  4*DIGITS  current BCD value, registered
- zero  output  1  high while count == 0, registered
- done  output  1  one-cycle pulse on the enabled 1 -> 0 transition
- wrapped  output  1  one-cycle pulse on the enabled 0 -> all-nines transition (WRAP=1 only; tied 0 when WRAP=0)

Behaviour:
- Clocking and priority: all state updates on posedge clk. Priority is rst > load > en.
- Reset: count=0, zero=1, done=0, wrapped=0. Reset mid-count discards the count.
- Load:
  - count <= load_val, with any digit above 9 (A..F) forced to 9.
  - zero is updated in the same edge to reflect the loaded value.
  - done=0, wrapped=0. en is ignored in that cycle.
- Decrement (en=1, load=0):
  - Digit 0 decrements by one.
  - Any digit at 0 that must borrow becomes 9 and passes the borrow to the next digit.
  - Borrow into digit k exists only when digits 0..k-1 are all 0.
  - Single-cycle latency: count reflects the new value after the edge.
- Reaching zero: when an enabled decrement takes count from 1 to 0, then on that edge zero<=1 and done<=1. done deasserts on the next edge.
- At zero with en=1:
  - WRAP=0: count holds at 0, done=0, zero stays 1.
  - WRAP=1: count <= all nines (e.g. 99 for DIGITS=2), zero<=0, wrapped<=1 for one cycle.
- Idle: en=0 and load=0 leaves count unchanged, and done/wrapped are 0.
- Load and en together: load wins. A load of 0 gives zero=1 with no done pulse.
- Register rules:
  - Outputs are registered.
  - zero is derived from the next-state value, so it is never one cycle stale.
  - No combinational path from inputs to outputs.
- Invariant: every count digit is always in the range 0..9.

Decomposition:
- Shared package/include:
  - BCD_MAX = 4'd9 and BCD_ZERO = 4'd0 constants.
  - Digit width constant 4.
- Sub-module bcd_digit_down, instantiated DIGITS times via generate.
  - Inputs: clk, rst, load, load_digit, borrow_in.
  - Outputs: digit, is_zero, borrow_out.
  - Holds one 4-bit register. Implements clamp-on-load and the 0 -> 9 borrow step.
- Top level:
  - Chains borrows: digit 0's borrow_in is en & ~all_zero, or en alone for WRAP=1.
  - Generates zero, done and wrapped.

Test Plan (DIGITS=2 unless stated):
1. Reset and load: assert rst, then load load_val=8'h25 -> count=00 and zero=1 during reset; count=25 and zero=0 one edge after load.
2. Borrow chain: load 8'h10, then en=1 for 1 cycle -> count=09, no done. Continue to 9 more enabled cycles -> count=00, done pulses exactly once on the 01 -> 00 edge, zero=1.
3. Hold vs wrap:
   - WRAP=0: at 00, en=1 for 3 cycles -> count stays 00, done=0.
   - WRAP=1: same stimulus -> 99, 98, 97, with wrapped pulsing on the first cycle only.
4. Invalid load: load 8'hA3 -> count=93. Load 8'hFF -> count=99.
5. Priority:
   - At count=40, assert load=1 (load_val 8'h07) with en=1 -> count=07, no decrement.
   - At count=07, assert rst=1 with load=1 -> count=00.
   - Apply rst at count=12 mid-run -> 00 next edge.
6. DIGITS=4: load 16'h1000, one enabled cycle -> 0999. Idle with en=0 for 5 cycles -> 0999 unchanged, no pulses.
